// File: rtl/alu_pkg.sv
// Shared types for the ALU command scheduler.
//   DATA_W / A_OP_W / B_OP_W : operand and opcode widths of the ALU port set
//   alu_cmd_t                : one buffered command (operands, enables, opcodes)
//   sched_state_e            : issue FSM states
package alu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned A_OP_W = 3;
  localparam int unsigned B_OP_W = 2;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              a_en;
    logic              b_en;
    logic [A_OP_W-1:0] a_op;
    logic [B_OP_W-1:0] b_op;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } sched_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO holding alu_cmd_t entries.
//   clk, rst_n          : clock, asynchronous active-low reset (empties FIFO)
//   push, push_data     : write request and entry (ignored when full)
//   pop                 : consume head entry (ignored when empty)
//   pop_data            : current head entry (valid when !empty)
//   full, empty         : occupancy flags derived from the pointers
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  alu_cmd_t push_data,
  input  logic     pop,
  output alu_cmd_t pop_data,
  output logic     full,
  output logic     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

  // Extra MSB on each pointer distinguishes full from empty when the
  // index bits coincide.
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  alu_cmd_t       mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/alu_cmd_sched.sv
// Command scheduler in front of the ALU.
// Buffers commands in a FIFO, issues one at a time on the ALU port set,
// captures C RES_LAT cycles after the issue strobe and returns it tagged.
//   clk, rst_n                     : clock, asynchronous active-low reset
//   cmd_valid / cmd_ready          : command stream handshake
//   cmd_a, cmd_b, cmd_a_en, cmd_b_en, cmd_a_op, cmd_b_op : command payload
//   A, B, a_en, b_en, a_op, b_op   : registered operands/controls to ALU
//   ALU_en                         : one-cycle issue strobe
//   C                              : ALU result
//   res_valid / res_ready          : result stream handshake
//   res_data, res_tag              : captured C and wrapping issue number
//   busy                           : FIFO non-empty or FSM not idle
module alu_cmd_sched
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned RES_LAT = 1,
  parameter int unsigned TAG_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic              cmd_a_en,
  input  logic              cmd_b_en,
  input  logic [A_OP_W-1:0] cmd_a_op,
  input  logic [B_OP_W-1:0] cmd_b_op,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic              a_en,
  output logic              b_en,
  output logic [A_OP_W-1:0] a_op,
  output logic [B_OP_W-1:0] b_op,
  output logic              ALU_en,
  input  logic [DATA_W-1:0] C,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [TAG_W-1:0]  res_tag,
  output logic              busy
);

  localparam int unsigned     CNT_W    = (RES_LAT > 1) ? $clog2(RES_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RES_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);

  sched_state_e     state;
  logic [CNT_W-1:0] wait_cnt;
  logic [TAG_W-1:0] issue_cnt;

  alu_cmd_t cmd_in;
  alu_cmd_t head;
  logic     fifo_full;
  logic     fifo_empty;
  logic     issue_go;

  assign cmd_in    = {cmd_a, cmd_b, cmd_a_en, cmd_b_en, cmd_a_op, cmd_b_op};
  assign cmd_ready = !fifo_full;
  assign busy      = !fifo_empty || (state != IDLE);

  // A held result blocks the next issue; a result being accepted this
  // edge frees the slot, so issue may proceed in the same cycle.
  assign issue_go  = (state == IDLE) && !fifo_empty && (!res_valid || res_ready);

  alu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_valid && cmd_ready),
    .push_data (cmd_in),
    .pop       (issue_go),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      issue_cnt <= '0;
      A         <= '0;
      B         <= '0;
      a_en      <= 1'b0;
      b_en      <= 1'b0;
      a_op      <= '0;
      b_op      <= '0;
      ALU_en    <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_tag   <= '0;
    end else begin
      ALU_en <= 1'b0;
      // Capture in WAIT below overrides this clear when both happen.
      if (res_valid && res_ready) res_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (issue_go) begin
            A      <= head.a;
            B      <= head.b;
            a_en   <= head.a_en;
            b_en   <= head.b_en;
            a_op   <= head.a_op;
            b_op   <= head.b_op;
            ALU_en <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= CNT_LOAD;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            res_data  <= C;
            res_valid <= 1'b1;
            res_tag   <= issue_cnt;
            issue_cnt <= issue_cnt + TAG_ONE;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt - CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sched.sv
module tb_alu_cmd_sched;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LAT   = 1;
  localparam int unsigned LAT3  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // main DUT (RES_LAT = 1)
  logic       cmd_valid, cmd_ready;
  logic [7:0] cmd_a, cmd_b;
  logic       cmd_a_en, cmd_b_en;
  logic [2:0] cmd_a_op;
  logic [1:0] cmd_b_op;
  logic [7:0] A, B;
  logic       a_en, b_en;
  logic [2:0] a_op;
  logic [1:0] b_op;
  logic       alu_en;
  logic [7:0] c = '0;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic [3:0] res_tag;
  logic       busy;

  // second DUT (RES_LAT = 3)
  logic       cmd3_valid, cmd3_ready;
  logic [7:0] A3, B3;
  logic       a_en3, b_en3;
  logic [2:0] a_op3;
  logic [1:0] b_op3;
  logic       alu_en3;
  logic [7:0] c3 = '0;
  logic       res3_valid, res3_ready;
  logic [7:0] res3_data;
  logic [3:0] res3_tag;
  logic       busy3;

  alu_cmd_sched #(.DEPTH(DEPTH), .RES_LAT(LAT), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_a_en(cmd_a_en), .cmd_b_en(cmd_b_en),
    .cmd_a_op(cmd_a_op), .cmd_b_op(cmd_b_op),
    .A(A), .B(B), .a_en(a_en), .b_en(b_en), .a_op(a_op), .b_op(b_op),
    .ALU_en(alu_en), .C(c),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tag(res_tag), .busy(busy)
  );

  alu_cmd_sched #(.DEPTH(DEPTH), .RES_LAT(LAT3), .TAG_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd3_valid), .cmd_ready(cmd3_ready),
    .cmd_a(8'h11), .cmd_b(8'h22), .cmd_a_en(1'b1), .cmd_b_en(1'b0),
    .cmd_a_op(3'd1), .cmd_b_op(2'd0),
    .A(A3), .B(B3), .a_en(a_en3), .b_en(b_en3), .a_op(a_op3), .b_op(b_op3),
    .ALU_en(alu_en3), .C(c3),
    .res_valid(res3_valid), .res_ready(res3_ready),
    .res_data(res3_data), .res_tag(res3_tag), .busy(busy3)
  );

  // Stub ALUs: XOR one cycle after the strobe; free-running count for LAT3.
  always @(posedge clk) if (alu_en) c <= A ^ B;
  always @(posedge clk) c3 <= c3 + 8'd1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    res_ready  = 1'b1;
    cmd3_valid = 1'b0;
    res3_ready = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       a_en;
    logic       b_en;
    logic [2:0] a_op;
    logic [1:0] b_op;
    logic [7:0] exp_c;
  } vec_t;

  task automatic set_cmd(input logic [7:0] a, input logic [7:0] b, input logic ae,
                         input logic be, input logic [2:0] ao, input logic [1:0] bo);
    cmd_a = a; cmd_b = b; cmd_a_en = ae; cmd_b_en = be; cmd_a_op = ao; cmd_b_op = bo;
  endtask

  // One command into an idle block; checks the cycle-exact issue/result timing.
  task automatic run_vec(input vec_t v, input int idx, input logic [3:0] tag);
    set_cmd(v.a, v.b, v.a_en, v.b_en, v.a_op, v.b_op);
    cmd_valid = 1'b1;
    res_ready = 1'b1;
    chk($sformatf("v%0d_cmd_ready", idx), cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    chk($sformatf("v%0d_alu_en_c1", idx), alu_en, 0);
    chk($sformatf("v%0d_busy", idx), busy, 1);
    step();
    chk($sformatf("v%0d_alu_en_c2", idx), alu_en, 1);
    chk($sformatf("v%0d_fields", idx), {A, B, a_en, b_en, a_op, b_op},
        {v.a, v.b, v.a_en, v.b_en, v.a_op, v.b_op});
    step();
    chk($sformatf("v%0d_alu_en_c3", idx), alu_en, 0);
    chk($sformatf("v%0d_res_valid_c3", idx), res_valid, 0);
    step();
    chk($sformatf("v%0d_res_valid_c4", idx), res_valid, 1);
    chk($sformatf("v%0d_res_data", idx), res_data, v.exp_c);
    chk($sformatf("v%0d_res_tag", idx), res_tag, tag);
    step();
    chk($sformatf("v%0d_res_cleared", idx), res_valid, 0);
    chk($sformatf("v%0d_idle", idx), busy, 0);
  endtask

  // Random-test reference model: queue of accepted commands, queue of
  // expected {data, tag} results, occupancy counter.
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       ae;
    logic       be;
    logic [2:0] ao;
    logic [1:0] bo;
  } rcmd_t;

  rcmd_t       cmdq[$];
  logic [11:0] expq[$];
  int          occ;
  logic [3:0]  tag_next;
  int          rnd_cyc;
  int          rnd_last;

  task automatic rnd_cycle(input int pv, input int pr);
    rcmd_t cur, mc;
    logic v, rdy, rv, rr;
    logic [7:0] rd, ed;
    logic [3:0] rt;
    logic [11:0] e;
    cur.a = 8'($urandom); cur.b = 8'($urandom);
    cur.ae = 1'($urandom); cur.be = 1'($urandom);
    cur.ao = 3'($urandom); cur.bo = 2'($urandom);
    set_cmd(cur.a, cur.b, cur.ae, cur.be, cur.ao, cur.bo);
    cmd_valid = ($urandom_range(99) < pv);
    res_ready = ($urandom_range(99) < pr);
    v = cmd_valid; rdy = cmd_ready; rv = res_valid; rr = res_ready;
    rd = res_data; rt = res_tag;
    step();
    rnd_cyc++;
    if (v && rdy) begin
      cmdq.push_back(cur);
      occ++;
    end
    if (rv && rr) begin
      chk("rnd_res_expected", expq.size() > 0, 1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("rnd_res", {rd, rt}, e);
      end
    end
    if (rv && !rr) chk("rnd_hold", {res_valid, res_data, res_tag}, {1'b1, rd, rt});
    if (alu_en) begin
      chk("rnd_issue_stall", rv && !rr, 0);
      if (rnd_last >= 0) chk("rnd_gap", (rnd_cyc - rnd_last) >= int'(LAT + 2), 1);
      rnd_last = rnd_cyc;
      chk("rnd_issue_has_cmd", cmdq.size() > 0, 1);
      if (cmdq.size() > 0) begin
        mc = cmdq.pop_front();
        chk("rnd_issue_fields", {A, B, a_en, b_en, a_op, b_op}, mc);
        ed = mc.a ^ mc.b;
        expq.push_back({ed, tag_next});
        tag_next = tag_next + 4'd1;
        occ--;
      end
    end
    chk("rnd_cmd_ready", cmd_ready, occ < int'(DEPTH));
  endtask

  vec_t vecs[6];

  initial begin
    int accepted, pulses, got, n, pushed, cyc, last_en;
    logic rdy, v;
    logic [7:0] ea, eb, ed, y;
    logic [3:0] et;
    logic [7:0] sa[17];
    logic [7:0] sb[17];
    logic seen;

    vecs[0] = '{8'h3C, 8'h0F, 1'b1, 1'b0, 3'd2, 2'd0, 8'h33};
    vecs[1] = '{8'hFF, 8'hFF, 1'b1, 1'b1, 3'd7, 2'd3, 8'h00};
    vecs[2] = '{8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 2'd0, 8'h00};
    vecs[3] = '{8'hA5, 8'h5A, 1'b0, 1'b1, 3'd5, 2'd1, 8'hFF};
    vecs[4] = '{8'h80, 8'h01, 1'b1, 1'b1, 3'd1, 2'd2, 8'h81};
    vecs[5] = '{8'h12, 8'h34, 1'b1, 1'b0, 3'd4, 2'd3, 8'h26};

    set_cmd('0, '0, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b1;
    cmd3_valid = 1'b0; res3_ready = 1'b1;
    #3;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_outputs", {A, B, a_en, b_en, a_op, b_op, alu_en, res_valid}, 0);
    chk("rst_res", {res_data, res_tag}, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("rel_cmd_ready", cmd_ready, 1);
    chk("rel_busy", busy, 0);

    // table-driven single commands, tags 0..5
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i, 4'(i));

    // backpressure: res_ready low, hold cmd_valid for 10 cycles
    res_ready = 1'b0;
    accepted = 0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      ea = 8'h40 + 8'(accepted);
      eb = 8'h0F * 8'(accepted);
      set_cmd(ea, eb, 1'b1, 1'b0, 3'd3, 2'd1);
      cmd_valid = 1'b1;
      rdy = cmd_ready;
      step();
      if (rdy) accepted++;
      if (alu_en) pulses++;
    end
    chk("bp_accepted", accepted, 5);
    chk("bp_issues", pulses, 1);
    chk("bp_cmd_ready_full", cmd_ready, 0);
    chk("bp_res_valid", res_valid, 1);
    chk("bp_res_data", res_data, 8'h40);
    chk("bp_res_tag", res_tag, 6);

    // full FIFO: push and issue-pop on the same edge
    set_cmd(8'hEE, 8'h11, 1'b0, 1'b1, 3'd6, 2'd2);
    cmd_valid = 1'b1;
    res_ready = 1'b1;
    chk("full_cmd_ready", cmd_ready, 0);
    step();
    cmd_valid = 1'b0;
    chk("full_issue", alu_en, 1);
    chk("full_issue_a", A, 8'h41);
    chk("full_occ_after", cmd_ready, 1);
    chk("full_res_consumed", res_valid, 0);
    got = 0;
    for (int i = 0; i < 40; i++) begin
      if (res_valid) begin
        if (got < 4) begin
          ea = 8'h40 + 8'(got + 1);
          eb = 8'h0F * 8'(got + 1);
          ed = ea ^ eb;
          et = 4'(7 + got);
          chk("drain_res", {res_data, res_tag}, {ed, et});
        end else begin
          chk("drain_extra_result", 1, 0);
        end
        got++;
      end
      step();
    end
    chk("drain_count", got, 4);
    chk("drain_idle", busy, 0);

    // 17 sequential commands: tags wrap, strobe spacing RES_LAT+2
    do_reset();
    for (int i = 0; i < 17; i++) begin
      sa[i] = 8'($urandom);
      sb[i] = 8'($urandom);
    end
    pushed = 0; n = 0; cyc = 0; last_en = -1;
    res_ready = 1'b1;
    while (n < 17 && cyc < 200) begin
      if (pushed < 17) set_cmd(sa[pushed], sb[pushed], 1'b1, 1'b1, 3'd2, 2'd1);
      cmd_valid = (pushed < 17);
      v = cmd_valid;
      rdy = cmd_ready;
      step();
      cyc++;
      if (v && rdy) pushed++;
      if (alu_en) begin
        if (last_en >= 0) chk("seq_gap", cyc - last_en, LAT + 2);
        last_en = cyc;
      end
      if (res_valid) begin
        ed = sa[n] ^ sb[n];
        et = 4'(n);
        chk("seq_res", {res_data, res_tag}, {ed, et});
        n++;
      end
    end
    cmd_valid = 1'b0;
    chk("seq_count", n, 17);

    // reset asserted while in WAIT
    do_reset();
    set_cmd(8'h5A, 8'hC3, 1'b1, 1'b1, 3'd7, 2'd3);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rw_outputs", {A, B, a_en, b_en, a_op, b_op, alu_en, res_valid}, 0);
    chk("rw_res", {res_data, res_tag}, 0);
    chk("rw_busy", busy, 0);
    chk("rw_cmd_ready", cmd_ready, 1);
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (res_valid || alu_en) seen = 1'b1;
    end
    chk("rw_no_result", seen, 0);
    chk("rw_cmd_ready_after", cmd_ready, 1);
    run_vec('{8'h0F, 8'hF0, 1'b1, 1'b1, 3'd3, 2'd2, 8'hFF}, 90, 4'd0);

    // randomized traffic against the queue model, then drain
    do_reset();
    cmdq.delete();
    expq.delete();
    occ = 0; tag_next = '0; rnd_cyc = 0; rnd_last = -1;
    for (int i = 0; i < 400; i++) rnd_cycle(60, 70);
    for (int i = 0; i < 200; i++) begin
      if (cmdq.size() == 0 && expq.size() == 0 && !res_valid) break;
      rnd_cycle(0, 100);
    end
    chk("rnd_drain", {cmdq.size() == 0, expq.size() == 0}, 2'b11);
    cmd_valid = 1'b0;

    // RES_LAT=3: C is sampled exactly three cycles after the strobe is sampled
    do_reset();
    cmd3_valid = 1'b1;
    step();
    cmd3_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (alu_en3) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk("l3_issue_seen", seen, 1);
    y = c3;
    chk("l3_issue_a", A3, 8'h11);
    step();
    chk("l3_strobe_one_cycle", alu_en3, 0);
    chk("l3_res_early1", res3_valid, 0);
    step();
    chk("l3_res_early2", res3_valid, 0);
    step();
    chk("l3_res_early3", res3_valid, 0);
    step();
    ed = y + 8'd3;
    chk("l3_res_valid", res3_valid, 1);
    chk("l3_res_data", res3_data, ed);
    chk("l3_res_tag", res3_tag, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
